// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM state
// encodings, address width, reset PC default and the NOP word.
// Used by fetch_unit (top) and fetch_queue (FETCH_QUEUE_EN build only).

package fetch_unit_pkg;

    // Instruction address width (PC and imem address).
    localparam int ADDR_W = 16;

    // Default PC loaded on reset.
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    // Value held in the instruction registers when nothing has been fetched.
    localparam logic [15:0] NOP_WORD = 16'h0000;

    // Fetch FSM states; the encoding is also the fetch_state debug output.
    typedef enum logic [1:0] {
        FS_IDLE   = 2'd0,
        FS_RUN    = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_t;

    // Sequential PC increment; wraps from 16'hFFFF to 16'h0000 silently.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + 1'b1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {pc, instr} prefetch FIFO used by fetch_unit when FETCH_QUEUE_EN
// is defined. Flush has priority over push/pop. A push while full and a pop
// while empty are ignored. The head reads as zero while the FIFO is empty so
// the outputs look like a freshly reset output register.

module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int width = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_pc,
    input  logic [width-1:0]  i_push_instr,
    input  logic              i_pop,
    output logic [1:0]        o_count,
    output logic [ADDR_W-1:0] o_head_pc,
    output logic [width-1:0]  o_head_instr
);

    logic [ADDR_W-1:0] r_pc    [2];
    logic [width-1:0]  r_instr [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_count;

    logic              w_do_push;
    logic              w_do_pop;

    // Qualify requests against the current occupancy.
    always_comb begin
        w_do_push = i_push && (r_count != 2'd2);
        w_do_pop  = i_pop  && (r_count != 2'd0);
    end

    // Pointer and occupancy bookkeeping; flush empties both entries at once.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; written only on an accepted push, never on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc[0]    <= '0;
            r_pc[1]    <= '0;
            r_instr[0] <= width'(NOP_WORD);
            r_instr[1] <= width'(NOP_WORD);
        end else if (w_do_push && !i_flush) begin
            r_pc[r_wr_ptr]    <= i_push_pc;
            r_instr[r_wr_ptr] <= i_push_instr;
        end
    end

    // Head of the FIFO drives the decode-side outputs.
    always_comb begin
        o_count      = r_count;
        o_head_pc    = '0;
        o_head_instr = width'(NOP_WORD);
        if (r_count != 2'd0) begin
            o_head_pc    = r_pc[r_rd_ptr];
            o_head_instr = r_instr[r_rd_ptr];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Holds the PC, drives the combinational instruction
// memory address, captures the returned word with its PC and presents both to
// decode. Execute can redirect the PC or halt fetching.
//
// Build option FETCH_QUEUE_EN: when defined, a 2-entry prefetch FIFO
// (fetch_queue) replaces the single output register so that one decode stall
// costs no bubble. When undefined, a single output register is used.
//
// Handshake to decode: if_valid/if_instr/if_pc form a valid/ready source.
// An instruction transfers on a cycle where if_valid && id_ready. While
// if_valid && !id_ready the outputs stay stable; if_valid only drops without
// a transfer on a redirect (flush) or reset.

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                width    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_add,
    input  logic [width-1:0]  imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              if_valid,
    input  logic              id_ready,
    output logic [width-1:0]  if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [1:0]        fetch_state
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;

    // High on a cycle where imem_data is captured and the PC advances.
    logic              w_fetch;
    // Common fetch enable: running, no redirect, no halt request.
    logic              w_fetch_allowed;

    always_comb begin
        w_fetch_allowed = (r_state == FS_RUN) && !redirect_valid && !halt_req;
    end

    // Fetch FSM and PC. Redirect outranks everything but reset and is
    // honoured in every state; halt freezes the PC until a redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FS_IDLE;
            r_pc    <= RESET_PC;
        end else if (redirect_valid) begin
            r_state <= FS_RUN;
            r_pc    <= redirect_pc;
        end else begin
            case (r_state)
                FS_IDLE: begin
                    // Single bubble after reset before the first fetch.
                    r_state <= FS_RUN;
                end
                FS_RUN: begin
                    if (halt_req) begin
                        r_state <= FS_HALTED;
                    end else if (w_fetch) begin
                        r_pc <= next_pc(r_pc);
                    end
                end
                FS_HALTED: begin
                    r_state <= FS_HALTED;
                end
                default: begin
                    r_state <= FS_IDLE;
                end
            endcase
        end
    end

    assign imem_add    = r_pc;
    assign fetch_state = r_state;

`ifdef FETCH_QUEUE_EN

    logic [1:0]        w_count;
    logic              w_pop;
    logic [ADDR_W-1:0] w_head_pc;
    logic [width-1:0]  w_head_instr;

    // Fetch while there is room; a full FIFO blocks fetch even if the head
    // drains this cycle. Draining continues while halted.
    always_comb begin
        w_fetch = w_fetch_allowed && (w_count != 2'd2);
        w_pop   = id_ready && (w_count != 2'd0) && !redirect_valid;
    end

    fetch_queue #(
        .width (width)
    ) u_fetch_queue (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (redirect_valid),
        .i_push       (w_fetch),
        .i_push_pc    (r_pc),
        .i_push_instr (imem_data),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr)
    );

    assign if_valid = (w_count != 2'd0);
    assign if_instr = w_head_instr;
    assign if_pc    = w_head_pc;

`else

    logic              r_if_valid;
    logic [width-1:0]  r_if_instr;
    logic [ADDR_W-1:0] r_if_pc;

    // The slot is free when empty or being consumed this cycle, so a stall
    // release refills in the same cycle with no bubble.
    always_comb begin
        w_fetch = w_fetch_allowed && (!r_if_valid || id_ready);
    end

    // Output register: flush on redirect, capture on fetch, otherwise clear
    // once decode takes the held instruction (covers halting).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_if_instr <= width'(NOP_WORD);
            r_if_pc    <= '0;
        end else if (redirect_valid) begin
            r_if_valid <= 1'b0;
        end else if (w_fetch) begin
            r_if_valid <= 1'b1;
            r_if_instr <= imem_data;
            r_if_pc    <= r_pc;
        end else if (r_if_valid && id_ready) begin
            r_if_valid <= 1'b0;
        end
    end

    assign if_valid = r_if_valid;
    assign if_instr = r_if_instr;
    assign if_pc    = r_if_pc;

`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. A queue-based model of the fetch stage (PC counter,
// up to CAP outstanding {pc, instr} entries) is checked against the DUT on
// every falling edge; directed scenarios add literal checks at key points.
// Builds with or without FETCH_QUEUE_EN.

module tb_fetch_unit;

`ifdef FETCH_QUEUE_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst            = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc    = 16'h0000;
    logic        halt_req       = 1'b0;
    logic        id_ready       = 1'b0;

    logic [15:0] imem_add;
    logic [15:0] imem_data;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [1:0]  fetch_state;

    // Instruction memory contents: byte swap of the address xor a constant.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    assign imem_data = mem_word(imem_add);

    fetch_unit #(
        .width    (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_add       (imem_add),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .if_valid       (if_valid),
        .id_ready       (id_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fetch_state    (fetch_state)
    );

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // exp_q holds {pc, instr} of instructions fetched but not yet consumed.
    logic [31:0] exp_q[$];
    logic [15:0] m_pc;
    int          m_state;     // 0 idle, 1 run, 2 halted
    bit          model_ok = 0;

    always @(posedge clk) begin : model_upd
        bit pop;
        bit room;
        if (rst) begin
            m_pc     = 16'h0000;
            m_state  = 0;
            exp_q.delete();
            model_ok = 1;
        end else begin
            pop  = (exp_q.size() > 0) && id_ready;
            if (CAP == 1) room = (exp_q.size() == 0) || id_ready;
            else          room = (exp_q.size() < CAP);
            if (redirect_valid) begin
                exp_q.delete();
                m_pc    = redirect_pc;
                m_state = 1;
            end else if (m_state == 0) begin
                m_state = 1;
            end else if (m_state == 1 && !halt_req) begin
                if (pop) void'(exp_q.pop_front());
                if (room) begin
                    exp_q.push_back({m_pc, mem_word(m_pc)});
                    m_pc = m_pc + 16'd1;
                end
            end else begin
                m_state = 2;
                if (pop) void'(exp_q.pop_front());
            end
        end
    end

    // Compare DUT to model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("if_valid", {31'd0, if_valid}, {31'd0, exp_q.size() != 0});
            chk("imem_add", {16'd0, imem_add}, {16'd0, m_pc});
            chk("fetch_state", {30'd0, fetch_state}, 32'(m_state));
            if (exp_q.size() != 0) begin
                chk("if_pc", {16'd0, if_pc}, {16'd0, exp_q[0][31:16]});
                chk("if_instr", {16'd0, if_instr}, {16'd0, exp_q[0][15:0]});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [15:0] rdy_pattern;

    initial begin
        // 1. reset two cycles, then sequential fetch
        rst = 1'b1;
        tick_n(2);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", {16'd0, if_instr}, 32'd0);
        chk("rst_pc", {16'd0, if_pc}, 32'd0);
        chk("rst_state", {30'd0, fetch_state}, 32'd0);
        chk("rst_add", {16'd0, imem_add}, 32'd0);

        rst = 1'b0;
        id_ready = 1'b1;
        tick();
        chk("idle_bubble_valid", {31'd0, if_valid}, 32'd0);
        chk("idle_to_run", {30'd0, fetch_state}, 32'd1);
        tick();
        chk("first_valid", {31'd0, if_valid}, 32'd1);
        chk("first_pc", {16'd0, if_pc}, 32'h0000);
        chk("first_instr", {16'd0, if_instr}, 32'h5A3C);
        chk("first_add", {16'd0, imem_add}, 32'h0001);
        tick_n(3);
        chk("seq_pc3", {16'd0, if_pc}, 32'h0003);

        // 2. decode stall for 3 cycles at if_pc=3
        id_ready = 1'b0;
        tick_n(3);
        chk("stall_pc", {16'd0, if_pc}, 32'h0003);
        chk("stall_valid", {31'd0, if_valid}, 32'd1);
`ifdef FETCH_QUEUE_EN
        chk("stall_add", {16'd0, imem_add}, 32'h0005);
`else
        chk("stall_add", {16'd0, imem_add}, 32'h0004);
`endif
        id_ready = 1'b1;
        tick();
        chk("release_pc", {16'd0, if_pc}, 32'h0004);

        // 3. redirect to 9 while valid
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0009;
        tick();
        chk("redir_flush", {31'd0, if_valid}, 32'd0);
        chk("redir_add", {16'd0, imem_add}, 32'h0009);
        redirect_valid = 1'b0;
        tick();
        chk("redir_valid", {31'd0, if_valid}, 32'd1);
        chk("redir_pc", {16'd0, if_pc}, 32'h0009);
        chk("redir_instr", {16'd0, if_instr}, 32'h533C);

        // 4. wrap at FFFF
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("wrap_ffff", {16'd0, if_pc}, 32'hFFFF);
        tick();
        chk("wrap_0000", {16'd0, if_pc}, 32'h0000);

        // 5. halt at if_pc=5 with decode stalled
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0005;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("pre_halt_pc", {16'd0, if_pc}, 32'h0005);
        halt_req = 1'b1;
        id_ready = 1'b0;
        tick();
        chk("halt_state", {30'd0, fetch_state}, 32'd2);
        chk("halt_held_pc", {16'd0, if_pc}, 32'h0005);
        chk("halt_add", {16'd0, imem_add}, 32'h0006);
        halt_req = 1'b0;
        tick_n(2);
        chk("halt_still_valid", {31'd0, if_valid}, 32'd1);
        chk("halt_frozen_add", {16'd0, imem_add}, 32'h0006);
        id_ready = 1'b1;
        tick();
        chk("halt_drained", {31'd0, if_valid}, 32'd0);
        chk("halt_state2", {30'd0, fetch_state}, 32'd2);
        tick();
        chk("halt_no_fetch", {31'd0, if_valid}, 32'd0);

        // redirect together with halt: redirect wins and resumes
        halt_req       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0000;
        tick();
        chk("resume_state", {30'd0, fetch_state}, 32'd1);
        chk("resume_add", {16'd0, imem_add}, 32'h0000);
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        tick();
        chk("resume_pc", {16'd0, if_pc}, 32'h0000);

        // 6. two-cycle stall, release without bubble, then flush a full queue
        id_ready = 1'b0;
        tick_n(2);
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_bubble", {31'd0, if_valid}, 32'd1);
        end
        id_ready = 1'b0;
        tick_n(2);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0020;
        id_ready       = 1'b1;
        tick();
        chk("flush_valid", {31'd0, if_valid}, 32'd0);
        redirect_valid = 1'b0;
        tick();
        chk("flush_refill", {16'd0, if_pc}, 32'h0020);

        // mid-operation reset with a held instruction
        id_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_valid", {31'd0, if_valid}, 32'd0);
        chk("midrst_state", {30'd0, fetch_state}, 32'd0);
        chk("midrst_add", {16'd0, imem_add}, 32'h0000);
        rst = 1'b0;
        id_ready = 1'b1;
        tick_n(2);
        chk("midrst_pc", {16'd0, if_pc}, 32'h0000);

        // irregular decode-ready pattern, checked by the model
        rdy_pattern = 16'b1011_0011_1000_1101;
        for (int i = 0; i < 16; i++) begin
            id_ready = rdy_pattern[i];
            tick();
        end
        id_ready = 1'b1;
        tick_n(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
